// File: rtl/mbist_mux_pkg.sv
// Shared types and default sizing for the MBIST / functional data-path selector.
package mbist_mux_pkg;

  typedef enum logic {
    MODE_NORMAL = 1'b0,
    MODE_TEST   = 1'b1
  } mode_e;

  localparam int unsigned DEFAULT_WIDTH     = 8;
  localparam int unsigned DEFAULT_CNT_WIDTH = 16;

endpackage : mbist_mux_pkg

// File: rtl/mux2_comb.sv
// Purely combinational 2:1 selector: y = sel ? b : a, bit-exact, zero latency.
module mux2_comb #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule : mux2_comb

// File: rtl/mbist_mode_mux.sv
// Memory-input selector between functional and MBIST data, plus registered
// output copy, mode tracking, mode-switch pulse and saturating test-cycle count.
module mbist_mode_mux
  import mbist_mux_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     normal_in,
  input  logic [WIDTH-1:0]     bist_in,
  input  logic                 NbarT,
  output logic [WIDTH-1:0]     out,
  output logic [WIDTH-1:0]     out_q,
  output logic                 mode_q,
  output logic                 mode_change,
  output logic [CNT_WIDTH-1:0] test_cycles
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]     data_q;
  mode_e                mode_reg_q, mode_reg_d;
  logic                 change_q, change_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // The memory-facing path never touches a flop, so reset cannot disturb it.
  mux2_comb #(.WIDTH(WIDTH)) u_mux (
    .a   (normal_in),
    .b   (bist_in),
    .sel (NbarT),
    .y   (out)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mode_reg_d = mode_e'(NbarT);
    change_d   = (mode_e'(NbarT) != mode_reg_q);
    cnt_d      = cnt_q;
    if (NbarT && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops
  // sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      mode_reg_q <= MODE_NORMAL;
      change_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      data_q     <= out;
      mode_reg_q <= mode_reg_d;
      change_q   <= change_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_q       = data_q;
  assign mode_q      = mode_reg_q;
  assign mode_change = change_q;
  assign test_cycles = cnt_q;

endmodule : mbist_mode_mux

// File: tb/tb_mbist_mode_mux.sv
// Self-checking bench: directed scenarios then randomized traffic, compared
// against a cycle-level behavioural model of the selector and its status.
module tb_mbist_mode_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  normal_in, bist_in;
  logic        nbart;
  logic [7:0]  out_w, out_q_w, out3_w, out_q3_w;
  logic        mode_q_w, mode_change_w, mode_q3_w, mode_change3_w;
  logic [15:0] test_cycles_w;
  logic [2:0]  test_cycles3_w;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [7:0] exp_out_q;
  bit         exp_mode, exp_chg;
  int         exp_cnt, exp_cnt3;

  always #5 clk = ~clk;

  mbist_mode_mux #(.WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .normal_in   (normal_in),
    .bist_in     (bist_in),
    .NbarT       (nbart),
    .out         (out_w),
    .out_q       (out_q_w),
    .mode_q      (mode_q_w),
    .mode_change (mode_change_w),
    .test_cycles (test_cycles_w)
  );

  mbist_mode_mux #(.WIDTH(8), .CNT_WIDTH(3)) dut3 (
    .clk         (clk),
    .rst         (rst),
    .normal_in   (normal_in),
    .bist_in     (bist_in),
    .NbarT       (nbart),
    .out         (out3_w),
    .out_q       (out_q3_w),
    .mode_q      (mode_q3_w),
    .mode_change (mode_change3_w),
    .test_cycles (test_cycles3_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] sel_ref(input bit t, input logic [7:0] n, input logic [7:0] b);
    return t ? b : n;
  endfunction

  task automatic check_comb(input string tag);
    check({tag, ".out"},  {24'h0, out_w},  {24'h0, sel_ref(nbart, normal_in, bist_in)});
    check({tag, ".out3"}, {24'h0, out3_w}, {24'h0, sel_ref(nbart, normal_in, bist_in)});
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".out_q"},        {24'h0, out_q_w},        {24'h0, exp_out_q});
    check({tag, ".mode_q"},       {31'h0, mode_q_w},       {31'h0, exp_mode});
    check({tag, ".mode_change"},  {31'h0, mode_change_w},  {31'h0, exp_chg});
    check({tag, ".test_cycles"},  {16'h0, test_cycles_w},  exp_cnt);
    check({tag, ".test_cycles3"}, {29'h0, test_cycles3_w}, exp_cnt3);
    check({tag, ".mode_change3"}, {31'h0, mode_change3_w}, {31'h0, exp_chg});
  endtask

  // Advance one rising edge and apply the model's update rules to the
  // inputs that were stable at that edge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) begin
      exp_out_q = '0; exp_mode = 0; exp_chg = 0; exp_cnt = 0; exp_cnt3 = 0;
    end else begin
      exp_out_q = sel_ref(nbart, normal_in, bist_in);
      exp_chg   = (nbart != exp_mode);
      exp_mode  = nbart;
      if (nbart) begin
        exp_cnt  = (exp_cnt  < 65535) ? exp_cnt  + 1 : 65535;
        exp_cnt3 = (exp_cnt3 < 7)     ? exp_cnt3 + 1 : 7;
      end
    end
    #1;
    check_regs(tag);
  endtask

  task automatic drive(input bit r, input bit t, input logic [7:0] n, input logic [7:0] b);
    @(negedge clk);
    rst = r; nbart = t; normal_in = n; bist_in = b;
    #1;
    check_comb("drive");
  endtask

  initial begin
    rst = 1'b1; nbart = 1'b0; normal_in = 8'h12; bist_in = 8'h34;
    exp_out_q = '0; exp_mode = 0; exp_chg = 0; exp_cnt = 0; exp_cnt3 = 0;

    tick("reset0");
    tick("reset1");

    // Combinational path with rst held high: registers stay cleared
    nbart = 1'b0; normal_in = 8'hAA; bist_in = 8'h55; #1;
    check("aa55_normal", {24'h0, out_w}, 32'hAA);
    nbart = 1'b1; #1;
    check("aa55_test", {24'h0, out_w}, 32'h55);
    nbart = 1'b0; normal_in = 8'hFF; bist_in = 8'h00; #1;
    check("ff00_normal", {24'h0, out_w}, 32'hFF);
    nbart = 1'b1; #1;
    check("ff00_test", {24'h0, out_w}, 32'h00);
    nbart = 1'b0; normal_in = 8'b1010_1010; bist_in = 8'b0101_0101; #1;
    check("alt_normal", {24'h0, out_w}, 32'hAA);
    nbart = 1'b1; #1;
    check("alt_test", {24'h0, out_w}, 32'h55);
    normal_in = 8'h33; bist_in = 8'h33;
    for (int i = 0; i < 4; i++) begin
      nbart = ~nbart; #1;
      check("equal_in", {24'h0, out_w}, 32'h33);
    end
    tick("reset_hold");

    // Five test-mode edges, then back to normal: one pulse per toggle, count 5 held
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 8'(i * 17), 8'(8'hC0 + i));
      tick("test_run");
    end
    check("five_cycles", {16'h0, test_cycles_w}, 32'd5);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'(8'h70 + i), 8'h0F);
      tick("normal_run");
    end
    check("count_held", {16'h0, test_cycles_w}, 32'd5);

    // Ten more test edges: small counter saturates at 7, wide one keeps going
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 8'($urandom), 8'($urandom));
      tick("sat_run");
    end
    check("sat3", {29'h0, test_cycles3_w}, 32'd7);
    check("wide15", {16'h0, test_cycles_w}, 32'd15);

    // Mid-operation reset for two cycles; out keeps following the inputs
    drive(1'b1, 1'b1, 8'h5A, 8'hA5);
    tick("mid_reset0");
    drive(1'b1, 1'b0, 8'h5A, 8'hA5);
    tick("mid_reset1");
    drive(1'b0, 1'b1, 8'h01, 8'h02);
    tick("post_reset");
    check("post_reset_pulse", {31'h0, mode_change_w}, 32'd1);

    // Randomized traffic, including unsampled NbarT glitches between edges
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 24) == 0), 1'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 5) == 0) begin
        nbart = ~nbart; #1;
        check_comb("glitch");
        nbart = ~nbart;
      end
      tick("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_mbist_mode_mux
